fir_result_buffer: RTL and testbench
====================================

Name: fir_result_buffer

Overview:
- Downstream stage of the FIR filter. Consumes the filter's 16-bit data_out / out_enable stream.
- Optionally decimates the stream, then rounds and saturates each sample to a narrower width.
- Buffers samples in a small FIFO and presents them to the next consumer on a ready/valid handshake.
- Also latches the filter's error flag and its own overflow/saturation events as sticky status.

Parameters:
- IN_W, 16, width of the FIR result input (unsigned).
- OUT_W, 8, width of the buffered output sample.
- SHIFT, 8, right-shift applied with round-half-up; 0 means no shift and no rounding.
- DEPTH, 8, FIFO entries; must be a power of 2 and ≥2.
- DECIM, 1, keep 1 of every DECIM input samples; must be ≥1.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- fir_data  in  IN_W  FIR result (connects to the FIR data_out).
- fir_valid  in  1  sample strobe (connects to the FIR out_enable); each high cycle is one sample.
- fir_error  in  1  FIR error flag.
- clear  in  1  synchronous flush of FIFO, pipeline, decimation phase and sticky flags.
- out_data  out  OUT_W  head-of-FIFO sample; valid only while out_valid=1.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts the head sample when out_valid & out_ready.
- count  out  $clog2(DEPTH)+1  current FIFO occupancy.
- overflow  out  1  sticky: a sample was dropped because the FIFO was full.
- sat_flag  out  1  sticky: a sample was saturated.
- err_latched  out  1  sticky: fir_error was seen high.

Behaviour:
- Reset (reset=0, asynchronous): FIFO empty, pointers 0, stage register invalid, decimation phase 0, all outputs 0.
- Decimation:
  - A phase counter 0..DECIM-1 advances on every fir_valid cycle and wraps to 0.
  - A sample is accepted only when fir_valid=1 and phase=0.
  - With DECIM=1 every sample is accepted.
- Arithmetic, computed in IN_W+1 bits:
  - r = (fir_data + (SHIFT>0 ? 2^(SHIFT-1) : 0)) >> SHIFT.
  - If r > 2^OUT_W-1, the output is 2^OUT_W-1 and sat_flag is set; otherwise the output is r[OUT_W-1:0].
- Pipeline and latency:
  - At edge N, an accepted sample's result is registered in the stage register.
  - At edge N+1, the stage register is written to the FIFO tail.
  - out_valid rises in the cycle after edge N+1, i.e. 2 cycles of latency from fir_valid into an empty FIFO.
  - The stage register accepts a new sample every cycle (no bubbles).
- FIFO:
  - Show-ahead: out_data always reflects the head entry.
  - Pop occurs when out_valid & out_ready; pop when empty is ignored.
  - Pointers wrap modulo DEPTH; count = writes − reads.
- Full:
  - If the stage register is valid, count=DEPTH and there is no pop that cycle, the sample is dropped, overflow is set and FIFO contents are unchanged.
  - If a pop occurs in the same cycle while full, the write succeeds and count stays DEPTH.
- Simultaneous push and pop at count=1: the head is replaced by the new entry and count stays 1.
- err_latched is set on any cycle with fir_error=1, independent of fir_valid.
- clear=1:
  - At the next edge: FIFO empty, stage invalid, phase 0, overflow/sat_flag/err_latched cleared.
  - clear overrides any push, pop or flag-set in the same cycle.
  - An input sample present in the clear cycle is discarded.
- Sticky flags stay set until clear or reset.
- Reset asserted mid-operation aborts immediately; a sample in flight is lost and out_valid drops asynchronously.
- No other state machine; the only control state is the phase counter, stage-valid bit and FIFO pointers.

Test Plan:
1. Rounding, defaults, out_ready=1:
   - fir_data 0x017F → out_data 0x01.
   - fir_data 0x0180 → out_data 0x02.
   - fir_data 0x00FF → out_data 0x01.
   - out_valid goes high 2 cycles after fir_valid; sat_flag stays 0.
2. Saturation: fir_data 0xFFFF then 0xFF80 → both give 0xFF; sat_flag=1; clear → sat_flag=0, count=0.
3. Overflow, out_ready=0, 10 consecutive samples 1..10 (×256):
   - count saturates at 8 and overflow=1.
   - Raise out_ready → outputs 1..8 in order, then out_valid=0.
4. Full with simultaneous pop: FIFO full with out_ready=1 and a continuous input stream → count holds 8, overflow stays 0, no sample lost.
5. DECIM=3: inputs 1..9 (×256) → outputs 1, 4, 7 only; clear mid-stream resets phase so the next input is kept.
6. Reset and error:
   - fir_error pulsed 1 cycle → err_latched=1 and held.
   - Assert reset with 5 entries buffered → out_valid, count and all flags 0 immediately.
   - The first sample after reset release appears 2 cycles after its fir_valid.

Source files
------------

// File: rtl/fir_result_buffer.sv
// Post-FIR result stage: optional decimation, round/saturate to OUT_W bits,
// then a show-ahead FIFO with ready/valid output and sticky status flags.
module fir_result_buffer #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 8,
    parameter int SHIFT = 8,
    parameter int DEPTH = 8,
    parameter int DECIM = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [IN_W-1:0]          fir_data,
    input  logic                     fir_valid,
    input  logic                     fir_error,
    input  logic                     clear,
    output logic [OUT_W-1:0]         out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     sat_flag,
    output logic                     err_latched
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;

    localparam logic [IN_W:0]  RND      = (IN_W+1)'((2**SHIFT) / 2);
    localparam logic [IN_W:0]  MAX_R    = (IN_W+1)'((2**OUT_W) - 1);
    localparam logic [CW-1:0]  FULL_CNT = CW'(DEPTH);
    localparam logic [PW-1:0]  LAST_PH  = PW'(DECIM - 1);

    logic [PW-1:0]    phase;
    logic             stage_valid;
    logic [OUT_W-1:0] stage_data;
    logic [OUT_W-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    logic [IN_W:0]    sum;
    logic [IN_W:0]    rounded;
    logic             sat_now;
    logic [OUT_W-1:0] result;
    logic             accept;
    logic             full;
    logic             pop;
    logic             push;
    logic             drop;

    // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
    always_comb begin
        sum     = {1'b0, fir_data} + RND;
        rounded = sum >> SHIFT;
        sat_now = (rounded > MAX_R);
        result  = sat_now ? '1 : rounded[OUT_W-1:0];
        accept  = fir_valid && (phase == '0);
        full    = (count == FULL_CNT);
        pop     = out_valid && out_ready;
        push    = stage_valid && (!full || pop);
        drop    = stage_valid && full && !pop;
    end

    assign out_valid = (count != '0);
    assign out_data  = out_valid ? mem[rd_ptr] : '0;

    // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase       <= '0;
            stage_valid <= 1'b0;
            stage_data  <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            overflow    <= 1'b0;
            sat_flag    <= 1'b0;
            err_latched <= 1'b0;
        end else if (clear) begin
            phase       <= '0;
            stage_valid <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            overflow    <= 1'b0;
            sat_flag    <= 1'b0;
            err_latched <= 1'b0;
        end else begin
            if (fir_valid) begin
                phase <= (phase == LAST_PH) ? '0 : phase + 1'b1;
            end
            stage_valid <= accept;
            if (accept) begin
                stage_data <= result;
            end
            if (accept && sat_now) begin
                sat_flag <= 1'b1;
            end
            if (fir_error) begin
                err_latched <= 1'b1;
            end
            if (drop) begin
                overflow <= 1'b1;
            end
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            // Push with pop leaves occupancy unchanged, which covers the full and count=1 cases.
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: the storage array has no reset; out_valid gates what is visible, so stale contents never leak.
    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem[wr_ptr] <= stage_data;
        end
    end

endmodule

// File: tb/tb_fir_result_buffer.sv
// Bench for fir_result_buffer: rounding vectors, directed corner sequences and
// random traffic compared against a queue-based reference model.
module tb_fir_result_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] fir_data;
    logic        fir_valid;
    logic        fir_error;
    logic        clear;
    logic        out_ready;

    logic [7:0]  out_data;
    logic        out_valid;
    logic [3:0]  count;
    logic        overflow;
    logic        sat_flag;
    logic        err_latched;

    logic [7:0]  d_out_data;
    logic        d_out_valid;
    logic [3:0]  d_count;
    logic        d_overflow;
    logic        d_sat_flag;
    logic        d_err_latched;

    int n_checks = 0;
    int n_fail   = 0;

    fir_result_buffer dut (
        .clk(clk), .reset(reset), .fir_data(fir_data), .fir_valid(fir_valid),
        .fir_error(fir_error), .clear(clear), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .count(count), .overflow(overflow), .sat_flag(sat_flag),
        .err_latched(err_latched)
    );

    fir_result_buffer #(.DECIM(3)) dut_d (
        .clk(clk), .reset(reset), .fir_data(fir_data), .fir_valid(fir_valid),
        .fir_error(fir_error), .clear(clear), .out_data(d_out_data), .out_valid(d_out_valid),
        .out_ready(out_ready), .count(d_count), .overflow(d_overflow), .sat_flag(d_sat_flag),
        .err_latched(d_err_latched)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model (DEPTH=8, DECIM=1, SHIFT=8, OUT_W=8): a queue of samples
    // plus a one-deep pending slot between input and queue.
    localparam int M_DEPTH = 8;
    int mq[$];
    bit m_pend;
    int m_pend_val;
    bit m_ovf, m_sat, m_err;

    task automatic model_reset();
        mq.delete();
        m_pend = 0;
        m_ovf  = 0;
        m_sat  = 0;
        m_err  = 0;
    endtask

    task automatic model_step();
        int r;
        if (clear) begin
            model_reset();
            return;
        end
        if (mq.size() > 0 && out_ready) void'(mq.pop_front());
        if (m_pend) begin
            if (mq.size() < M_DEPTH) mq.push_back(m_pend_val);
            else m_ovf = 1;
        end
        if (fir_error) m_err = 1;
        m_pend = fir_valid;
        if (fir_valid) begin
            r = (int'(fir_data) + 128) / 256;
            if (r > 255) begin
                m_sat = 1;
                r = 255;
            end
            m_pend_val = r;
        end
    endtask

    task automatic compare_model();
        check("out_valid", int'(out_valid), (mq.size() > 0) ? 1 : 0);
        check("count", int'(count), mq.size());
        if (mq.size() > 0) check("out_data", int'(out_data), mq[0]);
        check("overflow", int'(overflow), int'(m_ovf));
        check("sat_flag", int'(sat_flag), int'(m_sat));
        check("err_latched", int'(err_latched), int'(m_err));
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        compare_model();
    endtask

    typedef struct {
        logic [15:0] data;
        logic [7:0]  exp_out;
        logic        exp_sat;
    } round_vec_t;

    round_vec_t vecs[10];

    initial begin
        int next_exp;

        vecs[0] = '{16'h017F, 8'h01, 1'b0};
        vecs[1] = '{16'h0180, 8'h02, 1'b0};
        vecs[2] = '{16'h00FF, 8'h01, 1'b0};
        vecs[3] = '{16'h0000, 8'h00, 1'b0};
        vecs[4] = '{16'h007F, 8'h00, 1'b0};
        vecs[5] = '{16'h0080, 8'h01, 1'b0};
        vecs[6] = '{16'hFF7F, 8'hFF, 1'b0};
        vecs[7] = '{16'hFF80, 8'hFF, 1'b1};
        vecs[8] = '{16'hFFFF, 8'hFF, 1'b1};
        vecs[9] = '{16'h1234, 8'h12, 1'b0};

        reset = 1'b0; fir_data = '0; fir_valid = 0; fir_error = 0; clear = 0; out_ready = 0;
        #2;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_count", int'(count), 0);
        check("rst_flags", int'({overflow, sat_flag, err_latched}), 0);
        check("rst_out_data", int'(out_data), 0);
        model_reset();
        reset = 1'b1;
        tick();

        // Rounding / saturation table, with latency check on every vector.
        for (int i = 0; i < 10; i++) begin
            clear = 1; tick(); clear = 0;
            out_ready = 1;
            fir_data = vecs[i].data; fir_valid = 1;
            tick();
            fir_valid = 0;
            check("latency_early", int'(out_valid), 0);
            tick();
            check("round_valid", int'(out_valid), 1);
            check("round_data", int'(out_data), int'(vecs[i].exp_out));
            check("round_sat", int'(sat_flag), int'(vecs[i].exp_sat));
        end

        // Back-to-back saturating samples, then clear.
        clear = 1; tick(); clear = 0;
        out_ready = 0;
        fir_data = 16'hFFFF; fir_valid = 1; tick();
        fir_data = 16'hFF80; tick();
        fir_valid = 0; tick(); tick();
        check("sat_count", int'(count), 2);
        check("sat_head", int'(out_data), 8'hFF);
        check("sat_set", int'(sat_flag), 1);
        clear = 1; tick(); clear = 0;
        check("sat_cleared", int'(sat_flag), 0);
        check("sat_clr_count", int'(count), 0);

        // Overflow: 10 samples into a stalled 8-entry FIFO.
        out_ready = 0;
        for (int k = 1; k <= 10; k++) begin
            fir_data = 16'(k << 8); fir_valid = 1; tick();
        end
        fir_valid = 0; tick(); tick();
        check("ovf_count", int'(count), 8);
        check("ovf_flag", int'(overflow), 1);
        out_ready = 1;
        for (int k = 1; k <= 8; k++) begin
            check("ovf_drain_valid", int'(out_valid), 1);
            check("ovf_drain_data", int'(out_data), k);
            tick();
        end
        check("ovf_drained", int'(out_valid), 0);

        // Full FIFO with continuous input and simultaneous pops.
        clear = 1; tick(); clear = 0;
        next_exp = 1;
        for (int c = 0; c < 30; c++) begin
            fir_data = 16'((c + 1) << 8); fir_valid = 1;
            out_ready = (c >= 9);
            if (out_valid && out_ready) begin
                check("stream_order", int'(out_data), next_exp);
                next_exp++;
            end
            tick();
            if (c >= 9) check("full_hold", int'(count), 8);
        end
        check("stream_no_ovf", int'(overflow), 0);
        fir_valid = 0;
        for (int c = 0; c < 12; c++) begin
            if (out_valid && out_ready) begin
                check("stream_order", int'(out_data), next_exp);
                next_exp++;
            end
            tick();
        end
        check("stream_all_out", next_exp, 31);

        // Decimation by 3 on the second instance.
        clear = 1; tick(); clear = 0;
        out_ready = 0;
        for (int k = 1; k <= 9; k++) begin
            fir_data = 16'(k << 8); fir_valid = 1; tick();
        end
        fir_valid = 0; tick(); tick();
        check("decim_count", int'(d_count), 3);
        out_ready = 1;
        for (int k = 1; k <= 7; k += 3) begin
            check("decim_valid", int'(d_out_valid), 1);
            check("decim_data", int'(d_out_data), k);
            tick();
        end
        check("decim_empty", int'(d_out_valid), 0);
        out_ready = 0;
        fir_data = 16'h0100; fir_valid = 1; tick();
        fir_valid = 0; clear = 1; tick(); clear = 0;
        fir_data = 16'h0500; fir_valid = 1; tick();
        fir_valid = 0; tick();
        check("decim_clr_count", int'(d_count), 1);
        check("decim_clr_data", int'(d_out_data), 5);

        // Error latch, then asynchronous reset with data buffered.
        clear = 1; tick(); clear = 0;
        fir_error = 1; tick(); fir_error = 0;
        check("err_set", int'(err_latched), 1);
        tick(); tick(); tick();
        check("err_held", int'(err_latched), 1);
        out_ready = 0;
        for (int k = 1; k <= 5; k++) begin
            fir_data = 16'(k << 8); fir_valid = 1; tick();
        end
        fir_valid = 0; tick(); tick();
        check("pre_rst_count", int'(count), 5);
        reset = 1'b0;
        #1;
        check("arst_valid", int'(out_valid), 0);
        check("arst_count", int'(count), 0);
        check("arst_flags", int'({overflow, sat_flag, err_latched}), 0);
        model_reset();
        reset = 1'b1;
        fir_data = 16'h0300; fir_valid = 1; tick();
        fir_valid = 0;
        check("post_rst_early", int'(out_valid), 0);
        tick();
        check("post_rst_valid", int'(out_valid), 1);
        check("post_rst_data", int'(out_data), 3);

        // Random traffic against the model.
        for (int c = 0; c < 600; c++) begin
            fir_valid = ($urandom_range(0, 99) < 70);
            fir_data  = 16'($urandom);
            fir_error = ($urandom_range(0, 99) < 3);
            clear     = ($urandom_range(0, 99) < 3);
            out_ready = (c < 300) ? ($urandom_range(0, 99) < 50) : ($urandom_range(0, 99) < 85);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
